// File: rtl/ysyx_23060184_lsu_pkg.sv
// Shared encodings for the load/store unit: access codes, bus
// response codes and LSU FSM states.
package ysyx_23060184_lsu_pkg;

   localparam int WMASK_LENGTH   = 2;
   localparam int ROPCODE_LENGTH = 3;

   localparam logic [WMASK_LENGTH-1:0] WRITE_BYTE = 2'd0;
   localparam logic [WMASK_LENGTH-1:0] WRITE_HALF = 2'd1;
   localparam logic [WMASK_LENGTH-1:0] WRITE_WORD = 2'd2;

   localparam logic [ROPCODE_LENGTH-1:0] READ_BYTE  = 3'd0;
   localparam logic [ROPCODE_LENGTH-1:0] READ_BYTEU = 3'd1;
   localparam logic [ROPCODE_LENGTH-1:0] READ_HALF  = 3'd2;
   localparam logic [ROPCODE_LENGTH-1:0] READ_HALFU = 3'd3;
   localparam logic [ROPCODE_LENGTH-1:0] READ_WORD  = 3'd4;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   typedef enum logic [2:0] {
      LSU_IDLE = 3'd0,
      LSU_AR   = 3'd1,
      LSU_R    = 3'd2,
      LSU_AW_W = 3'd3,
      LSU_B    = 3'd4,
      LSU_DONE = 3'd5
   } lsu_state_e;

endpackage

// File: rtl/ysyx_23060184_LSU_Align.sv
// Byte-lane steering: store strobes/shift, load extract/extend and
// alignment check. Purely combinational.
module ysyx_23060184_LSU_Align
   import ysyx_23060184_lsu_pkg::*;
(
   input  logic [1:0]                off_i,
   input  logic                      is_rd_i,
   input  logic [WMASK_LENGTH-1:0]   wmask_i,
   input  logic [ROPCODE_LENGTH-1:0] ropcode_i,
   input  logic [31:0]               wdata_i,
   input  logic [31:0]               bus_rdata_i,
   output logic [3:0]                wstrb_o,
   output logic [31:0]               wdata_o,
   output logic [31:0]               rdata_o,
   output logic                      misalign_o
);

   logic [31:0] sh;
   logic        half_mis;
   logic        word_mis;

   assign sh       = bus_rdata_i >> {off_i, 3'b000};
   assign wdata_o  = wdata_i << {off_i, 3'b000};
   assign half_mis = off_i[0];
   assign word_mis = |off_i;

   always_comb begin
      wstrb_o = 4'b1111;
      unique case (wmask_i)
         WRITE_BYTE: wstrb_o = 4'b0001 << off_i;
         WRITE_HALF: wstrb_o = 4'b0011 << off_i;
         default:    wstrb_o = 4'b1111;
      endcase
   end

   always_comb begin
      rdata_o = sh;
      unique case (ropcode_i)
         READ_BYTE:  rdata_o = {{24{sh[7]}}, sh[7:0]};
         READ_BYTEU: rdata_o = {24'd0, sh[7:0]};
         READ_HALF:  rdata_o = {{16{sh[15]}}, sh[15:0]};
         READ_HALFU: rdata_o = {16'd0, sh[15:0]};
         default:    rdata_o = sh;
      endcase
   end

   always_comb begin
      misalign_o = 1'b0;
      if (is_rd_i) begin
         unique case (ropcode_i)
            READ_HALF, READ_HALFU: misalign_o = half_mis;
            READ_BYTE, READ_BYTEU: misalign_o = 1'b0;
            default:               misalign_o = word_mis;
         endcase
      end else begin
         unique case (wmask_i)
            WRITE_HALF: misalign_o = half_mis;
            WRITE_BYTE: misalign_o = 1'b0;
            default:    misalign_o = word_mis;
         endcase
      end
   end

endmodule

// File: rtl/ysyx_23060184_lsu.sv
// Load/store unit: turns decoded memory requests into single
// outstanding AXI4-Lite read or write transactions.
module ysyx_23060184_lsu
   import ysyx_23060184_lsu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      MemRead,
   input  logic                      MemWrite,
   input  logic [WMASK_LENGTH-1:0]   Wmask,
   input  logic [ROPCODE_LENGTH-1:0] Ropcode,
   input  logic [ADDR_W-1:0]         addr,
   input  logic [31:0]               wdata,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [31:0]               rdata,
   output logic                      err,
   output logic [ADDR_W-1:0]         m_araddr,
   output logic                      m_arvalid,
   input  logic                      m_arready,
   input  logic [31:0]               m_rdata,
   input  logic [1:0]                m_rresp,
   input  logic                      m_rvalid,
   output logic                      m_rready,
   output logic [ADDR_W-1:0]         m_awaddr,
   output logic                      m_awvalid,
   input  logic                      m_awready,
   output logic [31:0]               m_wdata,
   output logic [3:0]                m_wstrb,
   output logic                      m_wvalid,
   input  logic                      m_wready,
   input  logic [1:0]                m_bresp,
   input  logic                      m_bvalid,
   output logic                      m_bready
);

   lsu_state_e                state_q, state_d;
   logic [ADDR_W-1:0]         addr_q, addr_d;
   logic [ROPCODE_LENGTH-1:0] rop_q, rop_d;
   logic [31:0]               wdata_q, wdata_d;
   logic [3:0]                wstrb_q, wstrb_d;
   logic [31:0]               rdata_q, rdata_d;
   logic                      err_q, err_d;
   logic                      aw_done_q, aw_done_d;
   logic                      w_done_q, w_done_d;

   logic                      idle;
   logic [1:0]                al_off;
   logic [ROPCODE_LENGTH-1:0] al_rop;
   logic [3:0]                al_wstrb;
   logic [31:0]               al_wdata;
   logic [31:0]               al_rdata;
   logic                      al_mis;

   assign idle = (state_q == LSU_IDLE);

   // Incoming request drives the aligner at accept; later, the latched one.
   assign al_off = idle ? addr[1:0] : addr_q[1:0];
   assign al_rop = idle ? Ropcode : rop_q;

   ysyx_23060184_LSU_Align u_align (
      .off_i       (al_off),
      .is_rd_i     (MemRead),
      .wmask_i     (Wmask),
      .ropcode_i   (al_rop),
      .wdata_i     (wdata),
      .bus_rdata_i (m_rdata),
      .wstrb_o     (al_wstrb),
      .wdata_o     (al_wdata),
      .rdata_o     (al_rdata),
      .misalign_o  (al_mis)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rop_d     = rop_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      unique case (state_q)
         LSU_IDLE: begin
            if (in_valid) begin
               addr_d    = addr;
               rop_d     = Ropcode;
               wdata_d   = MemWrite ? al_wdata : 32'd0;
               wstrb_d   = MemWrite ? al_wstrb : 4'd0;
               rdata_d   = 32'd0;
               err_d     = 1'b0;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               if (MemRead && MemWrite) begin
                  err_d   = 1'b1;
                  state_d = LSU_DONE;
               end else if ((MemRead || MemWrite) && al_mis) begin
                  err_d   = 1'b1;
                  state_d = LSU_DONE;
               end else if (MemRead) begin
                  state_d = LSU_AR;
               end else if (MemWrite) begin
                  state_d = LSU_AW_W;
               end else begin
                  state_d = LSU_DONE;
               end
            end
         end
         LSU_AR: begin
            if (m_arready) state_d = LSU_R;
         end
         LSU_R: begin
            if (m_rvalid) begin
               err_d   = (m_rresp != AXI_RESP_OKAY);
               rdata_d = err_d ? 32'd0 : al_rdata;
               state_d = LSU_DONE;
            end
         end
         LSU_AW_W: begin
            aw_done_d = aw_done_q | m_awready;
            w_done_d  = w_done_q | m_wready;
            if (aw_done_d && w_done_d) state_d = LSU_B;
         end
         LSU_B: begin
            if (m_bvalid) begin
               err_d   = (m_bresp != AXI_RESP_OKAY);
               rdata_d = 32'd0;
               state_d = LSU_DONE;
            end
         end
         LSU_DONE: begin
            if (out_ready) state_d = LSU_IDLE;
         end
         default: state_d = LSU_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= LSU_IDLE;
         addr_q    <= '0;
         rop_q     <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         rop_q     <= rop_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   assign in_ready  = idle;
   assign out_valid = (state_q == LSU_DONE);
   assign rdata     = rdata_q;
   assign err       = err_q;
   assign m_araddr  = addr_q;
   assign m_arvalid = (state_q == LSU_AR);
   assign m_rready  = (state_q == LSU_R);
   assign m_awaddr  = addr_q;
   assign m_awvalid = (state_q == LSU_AW_W) && !aw_done_q;
   assign m_wvalid  = (state_q == LSU_AW_W) && !w_done_q;
   assign m_wdata   = wdata_q;
   assign m_wstrb   = wstrb_q;
   assign m_bready  = (state_q == LSU_B);

endmodule

// File: tb/tb_ysyx_23060184_lsu.sv
// Directed bench for the LSU with a delay-configurable AXI4-Lite slave.
module tb_ysyx_23060184_lsu;
   import ysyx_23060184_lsu_pkg::*;

   logic        clk = 0;
   logic        rstn = 0;
   logic        in_valid = 0, in_ready;
   logic        MemRead = 0, MemWrite = 0;
   logic [1:0]  Wmask = 0;
   logic [2:0]  Ropcode = 0;
   logic [31:0] addr = 0, wdata = 0;
   logic        out_valid, out_ready = 0;
   logic [31:0] rdata;
   logic        err;
   logic [31:0] m_araddr, m_awaddr, m_wdata, m_rdata = 0;
   logic        m_arvalid, m_arready = 0;
   logic [1:0]  m_rresp = 0, m_bresp = 0;
   logic        m_rvalid = 0, m_rready;
   logic        m_awvalid, m_awready = 0;
   logic [3:0]  m_wstrb;
   logic        m_wvalid, m_wready = 0;
   logic        m_bvalid = 0, m_bready;

   always #5 clk = ~clk;

   ysyx_23060184_lsu #(.ADDR_W(32)) dut (
      .clk(clk), .rstn(rstn),
      .in_valid(in_valid), .in_ready(in_ready),
      .MemRead(MemRead), .MemWrite(MemWrite),
      .Wmask(Wmask), .Ropcode(Ropcode),
      .addr(addr), .wdata(wdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .rdata(rdata), .err(err),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp),
      .m_rvalid(m_rvalid), .m_rready(m_rready),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
   );

   int n_cmp = 0, n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // ---------------- slave model ----------------
   int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
   logic [31:0] mem_rdata = 0;
   logic [1:0]  rresp_cfg = 0, bresp_cfg = 0;
   int n_ar = 0, n_b = 0;
   logic [3:0]  cap_strb = 0;
   logic [31:0] cap_wdata = 0;

   initial begin
      int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
      bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
      bit r_pend, b_pend, aw_got, w_got;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
      r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
            r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
            m_arready = 0; m_rvalid = 0; m_awready = 0;
            m_wready = 0; m_bvalid = 0;
         end else begin
            if (ar_hs) begin r_pend = 1; r_cnt = 0; ar_cnt = 0; n_ar++; end
            if (r_hs) r_pend = 0;
            if (aw_hs) begin aw_got = 1; aw_cnt = 0; end
            if (w_hs) begin w_got = 1; w_cnt = 0; end
            if (b_hs) begin b_pend = 0; n_b++; end
            if (aw_got && w_got) begin
               b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0;
            end
            m_arready = m_arvalid && (ar_cnt >= ar_dly);
            if (m_arvalid && !m_arready) ar_cnt++;
            m_rvalid = r_pend && (r_cnt >= r_dly);
            if (r_pend && !m_rvalid) r_cnt++;
            m_rdata = m_rvalid ? mem_rdata : 32'd0;
            m_rresp = rresp_cfg;
            m_awready = m_awvalid && (aw_cnt >= aw_dly);
            if (m_awvalid && !m_awready) aw_cnt++;
            m_wready = m_wvalid && (w_cnt >= w_dly);
            if (m_wvalid && !m_wready) w_cnt++;
            m_bvalid = b_pend && (b_cnt >= b_dly);
            if (b_pend && !m_bvalid) b_cnt++;
            m_bresp = bresp_cfg;
            ar_hs = m_arvalid && m_arready;
            r_hs  = m_rvalid && m_rready;
            aw_hs = m_awvalid && m_awready;
            w_hs  = m_wvalid && m_wready;
            b_hs  = m_bvalid && m_bready;
            if (w_hs) begin cap_strb = m_wstrb; cap_wdata = m_wdata; end
         end
      end
   end

   // ---------------- request driver ----------------
   typedef struct {
      string       name;
      logic        rd, wr;
      logic [1:0]  wm;
      logic [2:0]  rop;
      logic [31:0] addr, wdata, bus;
      logic [1:0]  rresp, bresp;
      logic        e_bus;
      int          e_lat;
      logic [31:0] e_rdata;
      logic        e_err;
      logic [3:0]  e_strb;
      logic [31:0] e_wdata;
   } vec_t;

   function automatic vec_t v(input string nm, input logic rd, wr,
      input logic [1:0] wm, input logic [2:0] rop,
      input logic [31:0] a, wd, bus, input logic [1:0] rr, br,
      input logic eb, input int el, input logic [31:0] er,
      input logic ee, input logic [3:0] es, input logic [31:0] ew);
      vec_t t;
      t.name = nm; t.rd = rd; t.wr = wr; t.wm = wm; t.rop = rop;
      t.addr = a; t.wdata = wd; t.bus = bus; t.rresp = rr;
      t.bresp = br; t.e_bus = eb; t.e_lat = el; t.e_rdata = er;
      t.e_err = ee; t.e_strb = es; t.e_wdata = ew;
      return t;
   endfunction

   bit saw_ar, ar_moved, inr_bad, wdrop, hold_bad;
   int lat;

   task automatic run(input vec_t t, input int hold);
      int a0, b0;
      logic [31:0] rd0;
      logic e0;
      a0 = n_ar; b0 = n_b;
      mem_rdata = t.bus; rresp_cfg = t.rresp; bresp_cfg = t.bresp;
      saw_ar = 0; ar_moved = 0; inr_bad = 0; wdrop = 0; hold_bad = 0;
      @(negedge clk);
      chk({t.name, ".in_ready"}, {31'd0, in_ready}, 32'd1);
      MemRead = t.rd; MemWrite = t.wr; Wmask = t.wm; Ropcode = t.rop;
      addr = t.addr; wdata = t.wdata; in_valid = 1;
      @(negedge clk);
      in_valid = 0; MemRead = 0; MemWrite = 0;
      lat = 1;
      while (!out_valid && lat < 60) begin
         saw_ar |= m_arvalid;
         if (m_arvalid && m_araddr !== t.addr) ar_moved = 1;
         if (in_ready) inr_bad = 1;
         if (m_awvalid && !m_wvalid) wdrop = 1;
         @(negedge clk);
         lat++;
      end
      chk({t.name, ".timeout"}, {31'd0, out_valid}, 32'd1);
      rd0 = rdata; e0 = err;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (!out_valid || rdata !== rd0 || err !== e0 || in_ready)
            hold_bad = 1;
      end
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      chk({t.name, ".lat"}, lat, t.e_lat);
      chk({t.name, ".rdata"}, rd0, t.e_rdata);
      chk({t.name, ".err"}, {31'd0, e0}, {31'd0, t.e_err});
      chk({t.name, ".n_ar"}, n_ar - a0, {31'd0, t.rd && t.e_bus});
      chk({t.name, ".n_b"}, n_b - b0, {31'd0, t.wr && t.e_bus});
      chk({t.name, ".arvalid"}, {31'd0, saw_ar}, {31'd0, t.rd && t.e_bus});
      if (t.wr && t.e_bus) begin
         chk({t.name, ".wstrb"}, {28'd0, cap_strb}, {28'd0, t.e_strb});
         chk({t.name, ".wdata"}, cap_wdata, t.e_wdata);
      end
   endtask

   vec_t vecs[14];
   vec_t hs;

   initial begin
      vecs[0]  = v("sb",  0, 1, WRITE_BYTE, 0, 32'h80000003, 32'h000000A5,
                   0, 0, 0, 1, 3, 0, 0, 4'b1000, 32'hA5000000);
      vecs[1]  = v("lb",  1, 0, 0, READ_BYTE, 32'h80000002, 0,
                   32'h12F03456, 0, 0, 1, 3, 32'hFFFFFFF0, 0, 0, 0);
      vecs[2]  = v("lbu", 1, 0, 0, READ_BYTEU, 32'h80000002, 0,
                   32'h12F03456, 0, 0, 1, 3, 32'h000000F0, 0, 0, 0);
      vecs[3]  = v("lh_mis", 1, 0, 0, READ_HALF, 32'h80000001, 0,
                   32'h12345678, 0, 0, 0, 1, 0, 1, 0, 0);
      vecs[4]  = v("lh",  1, 0, 0, READ_HALF, 32'h80000002, 0,
                   32'h80011234, 0, 0, 1, 3, 32'hFFFF8001, 0, 0, 0);
      vecs[5]  = v("lhu", 1, 0, 0, READ_HALFU, 32'h80000002, 0,
                   32'h80011234, 0, 0, 1, 3, 32'h00008001, 0, 0, 0);
      vecs[6]  = v("lw",  1, 0, 0, READ_WORD, 32'h80000004, 0,
                   32'hDEADBEEF, 0, 0, 1, 3, 32'hDEADBEEF, 0, 0, 0);
      vecs[7]  = v("sh",  0, 1, WRITE_HALF, 0, 32'h80000002, 32'h1234ABCD,
                   0, 0, 0, 1, 3, 0, 0, 4'b1100, 32'hABCD0000);
      vecs[8]  = v("sw",  0, 1, WRITE_WORD, 0, 32'h80000008, 32'h11223344,
                   0, 0, 0, 1, 3, 0, 0, 4'b1111, 32'h11223344);
      vecs[9]  = v("noop", 0, 0, 0, 0, 32'h80000000, 32'h5,
                   0, 0, 0, 0, 1, 0, 0, 0, 0);
      vecs[10] = v("both", 1, 1, WRITE_WORD, READ_WORD, 32'h80000000, 0,
                   0, 0, 0, 0, 1, 0, 1, 0, 0);
      vecs[11] = v("sw_mis", 0, 1, WRITE_WORD, 0, 32'h80000002, 32'h1,
                   0, 0, 0, 0, 1, 0, 1, 0, 0);
      vecs[12] = v("lw_slverr", 1, 0, 0, READ_WORD, 32'h80000010, 0,
                   32'hCAFEF00D, 2'b10, 0, 1, 3, 0, 1, 0, 0);
      vecs[13] = v("lb_pos", 1, 0, 0, READ_BYTE, 32'h80000000, 0,
                   32'hFFFFFF7F, 0, 0, 1, 3, 32'h0000007F, 0, 0, 0);

      repeat (3) @(negedge clk);
      chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst.valids", {28'd0, m_arvalid, m_awvalid, m_wvalid, m_rready},
          32'd0);
      chk("rst.bready_err", {30'd0, m_bready, err}, 32'd0);
      chk("rst.rdata", rdata, 32'd0);
      chk("rst.araddr", m_araddr, 32'd0);
      chk("rst.awaddr", m_awaddr, 32'd0);
      chk("rst.wdata", m_wdata, 32'd0);
      chk("rst.wstrb", {28'd0, m_wstrb}, 32'd0);
      rstn = 1;

      for (int i = 0; i < 14; i++) begin
         run(vecs[i], 0);
         chk({vecs[i].name, ".wdrop"}, {31'd0, wdrop}, 32'd0);
      end

      // W accepted three cycles ahead of AW, slave error on B
      w_dly = 0; aw_dly = 3;
      hs = v("wr_order", 0, 1, WRITE_WORD, 0, 32'h80000020, 32'h0BADF00D,
             0, 0, 2'b10, 1, 6, 0, 1, 4'b1111, 32'h0BADF00D);
      run(hs, 0);
      chk("wr_order.wdrop", {31'd0, wdrop}, 32'd1);
      aw_dly = 0;

      // back-pressure on AR, R and the WB side
      ar_dly = 4; r_dly = 2;
      hs = v("bp", 1, 0, 0, READ_HALFU, 32'h80000042, 0, 32'hBEEF0000,
             0, 0, 1, 9, 32'h0000BEEF, 0, 0, 0);
      run(hs, 3);
      chk("bp.araddr_stable", {31'd0, ar_moved}, 32'd0);
      chk("bp.in_ready_low", {31'd0, inr_bad}, 32'd0);
      chk("bp.hold", {31'd0, hold_bad}, 32'd0);
      ar_dly = 0; r_dly = 0;

      // reset while waiting in R
      r_dly = 5; mem_rdata = 32'h11111111; rresp_cfg = 0;
      @(negedge clk);
      MemRead = 1; Ropcode = READ_WORD; addr = 32'h80000030; in_valid = 1;
      @(negedge clk);
      in_valid = 0; MemRead = 0;
      for (int k = 0; k < 20 && !m_rready; k++) @(negedge clk);
      chk("rst_mid.in_r", {31'd0, m_rready}, 32'd1);
      rstn = 0;
      #1;
      chk("rst_mid.rready", {31'd0, m_rready}, 32'd0);
      chk("rst_mid.in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_mid.valids", {29'd0, m_arvalid, out_valid, m_awvalid}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rstn = 1; r_dly = 0;
      hs = v("post_rst", 1, 0, 0, READ_WORD, 32'h80000034, 0, 32'h600DCAFE,
             0, 0, 1, 3, 32'h600DCAFE, 0, 0, 0);
      run(hs, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end

endmodule
